pos_pid_mc: RTL

Parametrised, time-multiplexed multi-channel position PID for the galvo loop. One signed multiplier is shared across NCH channels, for example X/Y mirrors. Each channel keeps its own integrator and previous-error state. The block sits between the ADC sample frame and the DAC driver. All channel outputs are double-buffered and update together, with a one-cycle valid strobe.

---
 rtl/pos_pid_mc_if.sv | 31 +++
 rtl/pos_pid_mc.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pos_pid_mc_if.sv
// Sample/DAC bus for pos_pid_mc: frame handshake and output codes.
// Ports: sample_valid/ready, pos_target, pos_adc, pos_dac, dac_valid.
interface pos_pid_mc_if #(
    parameter int NCH = 2,
    parameter int DW  = 16
) ();
    logic              sample_valid;
    logic              sample_ready;
    logic [NCH*DW-1:0] pos_target;
    logic [NCH*DW-1:0] pos_adc;
    logic [NCH*DW-1:0] pos_dac;
    logic              dac_valid;

    modport master (
        output sample_valid,
        output pos_target,
        output pos_adc,
        input  sample_ready,
        input  pos_dac,
        input  dac_valid
    );

    modport slave (
        input  sample_valid,
        input  pos_target,
        input  pos_adc,
        output sample_ready,
        output pos_dac,
        output dac_valid
    );
endinterface

// File: rtl/pos_pid_mc.sv
// Time-multiplexed multi-channel position PID sharing one signed multiplier.
// Ports: clk_pid, sys_rstn (async low), pid_en, bus (pos_pid_mc_if.slave:
//   sample handshake, targets, adc, pos_dac, dac_valid), kp/ki/kd,
//   dac_limit, pid_i_saturation, overrun. Optional PID_DEADBAND_EN adds
//   err_deadband: small errors are forced to zero.
module pos_pid_mc #(
    parameter int NCH  = 2,
    parameter int DW   = 16,
    parameter int GW   = 16,
    parameter int FRAC = 10,
    parameter int ACCW = 32
) (
    input  logic              clk_pid,
    input  logic              sys_rstn,
    input  logic              pid_en,
    pos_pid_mc_if.slave       bus,
    input  logic [NCH*GW-1:0] kp,
    input  logic [NCH*GW-1:0] ki,
    input  logic [NCH*GW-1:0] kd,
    input  logic [DW-1:0]     dac_limit,
    input  logic [ACCW-2:0]   pid_i_saturation,
`ifdef PID_DEADBAND_EN
    input  logic [DW-1:0]     err_deadband,
`endif
    output logic              overrun
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW = ACCW + 2;
    localparam int PW = GW + ACCW;
    localparam logic [DW-1:0] MID  = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] LMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [NCH*DW-1:0] MIDS = {NCH{MID}};
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ERR  = 3'd1;
    localparam logic [2:0] S_MP   = 3'd2;
    localparam logic [2:0] S_MI   = 3'd3;
    localparam logic [2:0] S_MD   = 3'd4;
    localparam logic [2:0] S_SUM  = 3'd5;
    localparam logic [2:0] S_OUT  = 3'd6;

    logic [2:0]         state;
    logic [CW-1:0]      ch;
    logic               armed;
    logic [NCH*DW-1:0]  tgt_s, adc_s;
    logic [NCH*GW-1:0]  kp_s, ki_s, kd_s;
    logic [DW-1:0]      lim_s;
    logic [ACCW-2:0]    isat_s;
    logic signed [ACCW-1:0] integ [NCH];
    logic signed [ACCW-1:0] perr  [NCH];
    logic signed [ACCW-1:0] err_r, der_r;
    logic signed [SW-1:0]   acc;
    logic [NCH*DW-1:0]  stg, dac_q;
    logic               vld_q, ovr_q;

    logic               accept;
    logic [DW-1:0]      tgt_c, adc_c;
    logic signed [DW:0] err_d, err_f;
    logic signed [ACCW-1:0] err_x, integ_c, perr_c, der_c;
    logic signed [ACCW:0]   cand, ncand, isat_w;
    logic               in_bnd;
    logic signed [GW-1:0]   g_op;
    logic signed [ACCW-1:0] m_op;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] term;
    logic signed [SW-1:0]   term_w, lim_w, nlim_w;
    logic [DW-1:0]      lim_c, o_c;
    logic [NCH*DW-1:0]  stg_n;

    assign bus.sample_ready = armed & pid_en & (state == S_IDLE);
    assign bus.pos_dac      = dac_q;
    assign bus.dac_valid    = vld_q;
    assign overrun          = ovr_q;
    assign accept = bus.sample_valid & bus.sample_ready;

    assign tgt_c = tgt_s[ch*DW +: DW];
    assign adc_c = adc_s[ch*DW +: DW];
    assign err_d = $signed({1'b0, tgt_c}) - $signed({1'b0, adc_c});

`ifdef PID_DEADBAND_EN
    logic [DW-1:0] db_s;
    logic [DW:0]   err_mag;
    assign err_mag = err_d[DW] ? $unsigned(-err_d) : $unsigned(err_d);
    assign err_f   = (err_mag <= {1'b0, db_s}) ? '0 : err_d;
`else
    assign err_f = err_d;
`endif

    assign err_x   = {{(ACCW-DW-1){err_f[DW]}}, err_f};
    assign integ_c = integ[ch];
    assign perr_c  = perr[ch];
    assign der_c   = err_x - perr_c;

    // Integrator only moves if the candidate stays strictly inside +-isat.
    assign cand   = {integ_c[ACCW-1], integ_c} + {err_x[ACCW-1], err_x};
    assign ncand  = -cand;
    assign isat_w = {2'b00, isat_s};
    assign in_bnd = (ncand < isat_w) && (cand < isat_w);

    always_comb begin
        g_op = '0;
        m_op = '0;
        unique case (1'b1)
            (state == S_MP): begin
                g_op = kp_s[ch*GW +: GW];
                m_op = err_r;
            end
            (state == S_MI): begin
                g_op = ki_s[ch*GW +: GW];
                m_op = integ_c;
            end
            (state == S_MD): begin
                g_op = kd_s[ch*GW +: GW];
                m_op = der_r;
            end
            default: ;
        endcase
    end

    assign prod   = g_op * m_op;
    assign term   = ACCW'(prod >>> FRAC);
    assign term_w = {{2{term[ACCW-1]}}, term};

    assign lim_c  = (lim_s > LMAX) ? LMAX : lim_s;
    assign lim_w  = {{(SW-DW){1'b0}}, lim_c};
    assign nlim_w = -lim_w;

    // acc holds P+I+D with two guard bits, so it never wraps.
    always_comb begin
        if (acc > lim_w)
            o_c = MID + lim_c;
        else if (acc < nlim_w)
            o_c = MID - lim_c;
        else
            o_c = MID + acc[DW-1:0];
    end

    always_comb begin
        stg_n = stg;
        stg_n[ch*DW +: DW] = o_c;
    end

    always_ff @(posedge clk_pid or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state  <= S_IDLE;
            ch     <= '0;
            armed  <= 1'b0;
            tgt_s  <= '0;
            adc_s  <= '0;
            kp_s   <= '0;
            ki_s   <= '0;
            kd_s   <= '0;
            lim_s  <= '0;
            isat_s <= '0;
`ifdef PID_DEADBAND_EN
            db_s   <= '0;
`endif
            for (int i = 0; i < NCH; i++) begin
                integ[i] <= '0;
                perr[i]  <= '0;
            end
            err_r  <= '0;
            der_r  <= '0;
            acc    <= '0;
            stg    <= MIDS;
            dac_q  <= MIDS;
            vld_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            armed <= 1'b1;
            vld_q <= 1'b0;
            ovr_q <= pid_en & bus.sample_valid & (state != S_IDLE);
            if (!pid_en) begin
                // Disable parks the outputs and forgets all loop history.
                state <= S_IDLE;
                ch    <= '0;
                for (int i = 0; i < NCH; i++) begin
                    integ[i] <= '0;
                    perr[i]  <= '0;
                end
                acc   <= '0;
                stg   <= MIDS;
                dac_q <= MIDS;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            tgt_s  <= bus.pos_target;
                            adc_s  <= bus.pos_adc;
                            kp_s   <= kp;
                            ki_s   <= ki;
                            kd_s   <= kd;
                            lim_s  <= dac_limit;
                            isat_s <= pid_i_saturation;
`ifdef PID_DEADBAND_EN
                            db_s   <= err_deadband;
`endif
                            ch     <= '0;
                            state  <= S_ERR;
                        end
                    end
                    S_ERR: begin
                        if (in_bnd)
                            integ[ch] <= cand[ACCW-1:0];
                        perr[ch] <= err_x;
                        err_r    <= err_x;
                        der_r    <= der_c;
                        state    <= S_MP;
                    end
                    S_MP: begin
                        acc   <= term_w;
                        state <= S_MI;
                    end
                    S_MI: begin
                        acc   <= acc + term_w;
                        state <= S_MD;
                    end
                    S_MD: begin
                        acc   <= acc + term_w;
                        state <= S_SUM;
                    end
                    S_SUM: begin
                        stg <= stg_n;
                        if (ch == LAST) begin
                            // Last channel folds straight into the output
                            // so all codes land together in OUT.
                            dac_q <= stg_n;
                            vld_q <= 1'b1;
                            state <= S_OUT;
                        end else begin
                            ch    <= ch + 1'b1;
                            state <= S_ERR;
                        end
                    end
                    S_OUT:   state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
